// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
// Bit-serial adder controller. It accepts two WIDTH-bit operands plus a
// carry-in, then walks them LSB first through an external 1-bit full adder.
// It takes one bit per clock and collects the sum bits and the final carry.
// The result is held in DONE until the consumer takes it.
module serial_add_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    // operand request
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    // external full adder
    output logic             fa_en_o,
    output logic             fa_a_o,
    output logic             fa_b_o,
    output logic             fa_c_o,
    input  logic             fa_s_i,
    input  logic             fa_c_i,
    // result
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             busy_o
);

    // The bit index only has to reach WIDTH-1. Keep it at least one bit wide.
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    logic               accept;
    logic               in_run;

    // Handshake decode. Clear beats a new request in the same cycle.
    always_comb begin
        in_run     = (state_q == RUN);
        in_ready_o = (state_q == IDLE);
        accept     = in_ready_o && in_valid_i && !clear_i;
    end

    // Next-state logic and datapath updates. Every target starts from a hold default.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        idx_d   = idx_q;

        if (clear_i) begin
            // Abort the operation. Keep sum/carry as they are, so the last
            // visible result is not disturbed by the abort itself.
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_d     = a_i;
                        b_d     = b_i;
                        carry_d = cin_i;
                        idx_d   = '0;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    // One bit per edge. The adder result comes back combinationally.
                    sum_d[idx_q] = fa_s_i;
                    carry_d      = fa_c_i;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                    end
                end
                DONE: begin
                    // Leave on the handshake edge. No new accept is taken
                    // until the next cycle, when IDLE raises in_ready_o.
                    if (out_ready_i) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers. Asynchronous reset clears everything.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
        end
    end

    // Adder drive comes from registered state only. It is forced to zero outside RUN.
    always_comb begin
        fa_en_o = in_run;
        fa_a_o  = in_run & a_q[idx_q];
        fa_b_o  = in_run & b_q[idx_q];
        fa_c_o  = in_run & carry_q;
    end

    // Result and status outputs. sum/cout keep the last result after it is consumed.
    always_comb begin
        out_valid_o = (state_q == DONE);
        busy_o      = (state_q != IDLE);
        sum_o       = sum_q;
        cout_o      = carry_q;
    end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, default 4, operand width in bits; legal range 2..16.
REQ-002 SHALL have port: clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_ni  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: clear_i  input  1  synchronous abort; returns to IDLE and discards the operation in flight.
REQ-005 SHALL have port: in_valid_i  input  1  operand request valid.
REQ-006 SHALL have port: in_ready_o  output  1  block can accept operands.
REQ-007 SHALL have port: a_i  input  WIDTH  operand A.
REQ-008 SHALL have port: b_i  input  WIDTH  operand B.
REQ-009 SHALL have port: cin_i  input  1  initial carry-in.
REQ-010 SHALL have port: fa_en_o  output  1  full adder in use this cycle.
REQ-011 SHALL have port: fa_a_o  output  1  adder bit A.
REQ-012 SHALL have port: fa_b_o  output  1  adder bit B.
REQ-013 SHALL have port: fa_c_o  output  1  adder carry-in.
REQ-014 SHALL have port: fa_s_i  input  1  sum bit returned by the external 1-bit full adder (combinational path).
REQ-015 SHALL have port: fa_c_i  input  1  carry-out returned by the adder.
REQ-016 SHALL have port: out_valid_o  output  1  result valid.
REQ-017 SHALL have port: out_ready_i  input  1  consumer accepts result.
REQ-018 SHALL have port: sum_o  output  WIDTH  result sum.
REQ-019 SHALL have port: cout_o  output  1  final carry-out.
REQ-020 SHALL have port: busy_o  output  1  state is not IDLE.

Function
REQ-021 SHALL implement FSM states IDLE, RUN, DONE; one-hot or binary encoding is free.
REQ-022 Accept condition SHALL be IDLE & in_valid_i & in_ready_o & !clear_i.
- in_ready_o = (state==IDLE).
- No accept in RUN or DONE.
REQ-023 On accept, SHALL latch a_i, b_i into operand registers, cin_i into carry register, set bit index to 0 and go to RUN.
REQ-024 In RUN, drive adder from registered state only:
- fa_en_o=1.
- fa_a_o=A[idx], fa_b_o=B[idx], fa_c_o=carry.
REQ-025 Each RUN edge SHALL capture:
- sum[idx] <= fa_s_i.
- carry <= fa_c_i.
- idx <= idx+1.
REQ-026 RUN SHALL process bits LSB first, exactly WIDTH cycles; the edge capturing bit WIDTH-1 SHALL move to DONE.
REQ-027 Latency: accept at edge k, then out_valid_o=1 after edge k+WIDTH.
REQ-028 In DONE:
- out_valid_o=1.
- sum_o=sum register, cout_o=carry register.
- All held stable until out_ready_i=1.
REQ-029 DONE & out_ready_i SHALL go to IDLE on that edge; no same-cycle re-accept (in_ready_o rises next cycle).
REQ-030 Outside RUN, fa_en_o, fa_a_o, fa_b_o and fa_c_o SHALL all be 0.
REQ-031 sum_o and cout_o SHALL hold last result in IDLE; they are meaningful only while out_valid_o=1.
REQ-032 Result SHALL equal (A + B + cin) mod 2^WIDTH, with cout_o = bit WIDTH of the full sum.
REQ-033 clear_i=1 in any state SHALL force IDLE on next edge, leave sum/carry unchanged and drop out_valid_o; clear_i has priority over accept and over the out_ready_i handshake.
REQ-034 Changes of a_i, b_i and cin_i after accept SHALL NOT affect the result.

Reset
REQ-035 While rst_ni=0, asynchronously:
- State=IDLE, idx=0.
- Operand, sum and carry registers cleared.
- Outputs: in_ready_o=1 (after reset), out_valid_o=0, busy_o=0, fa_*_o=0, sum_o=0, cout_o=0.
REQ-036 Reset asserted mid-RUN or in DONE SHALL abort immediately with no result emitted; the first accept after rst_ni rises SHALL behave as from power-up.

Verification
REQ-037 Bench SHALL connect a golden 1-bit full-adder model to fa_*, and cover:
- a=3,b=5,cin=0 -> after 4 cycles sum_o=8,cout_o=0; fa_a_o seq 1,1,0,0, fa_b_o seq 1,0,1,0.
- a=15,b=1,cin=0 -> sum_o=0,cout_o=1; a=15,b=15,cin=1 -> sum_o=15,cout_o=1.
- out_ready_i low 5 cycles in DONE -> out_valid_o, sum_o and cout_o stable; in_valid_i held high is not accepted until the cycle after release.
- rst_ni pulsed low at RUN bit 2 -> all outputs 0 immediately; next op a=7,b=9 -> sum_o=0,cout_o=1.
- clear_i at RUN bit 1 and clear_i together with in_valid_i in IDLE -> IDLE, no out_valid_o, no accept; random a/b/cin on WIDTH=4 and 8 against the arithmetic model.
